// File: rtl/apb_slave_mem.sv
// apb_slave_mem
//   APB completer with a small word-addressed register memory and a
//   programmable number of wait states per transfer.  Used as the
//   bus-functional target behind the AHB-to-APB bridge.
//
// Parameters
//   DEPTH       : number of 32-bit words (power of 2, 2..256)
//   WAIT_STATES : Pready-low cycles inserted in the access phase (0..15)
//   BASE_ADDR   : byte address of word 0 (DEPTH*4 aligned)
//
// Ports
//   Pclk     in   APB clock, all state changes on the rising edge
//   Presetn  in   synchronous active-low reset
//   Psel     in   slave select
//   Penable  in   access-phase strobe
//   Pwrite   in   1 = write, 0 = read
//   Paddr    in   byte address (captured in the setup cycle only)
//   Pdata    in   write data (captured in the setup cycle only)
//   Pready   out  transfer complete (combinational from state/inputs)
//   Prdata   out  read data, zero whenever not completing a good read
//   Pslverr  out  error response, only ever high together with Pready
module apb_slave_mem #(
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        Pclk,
    input  logic        Presetn,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pdata,
    output logic        Pready,
    output logic [31:0] Prdata,
    output logic        Pslverr
);

    localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WS_LD = 4'(WAIT_STATES);

    // The wait counter is only 4 bits wide.
    if (WAIT_STATES > 15 || WAIT_STATES < 0) begin : g_bad_wait_states
        $error("apb_slave_mem: WAIT_STATES must be in 0..15");
    end

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [3:0]         cnt_r;
    logic [31:0]        addr_r;
    logic               write_r;
    logic [31:0]        wdata_r;
    logic [31:0]        mem_r [DEPTH];

    logic [31:0]        offset_s;
    logic               err_s;
    logic [IDX_W-1:0]   idx_s;
    logic               do_write_s;
    logic               ready_s;
    logic               slverr_s;
    logic [31:0]        rdata_s;

    // Decode of the latched address: misaligned, below base, or past the end.
    always_comb begin
        offset_s = addr_r - BASE_ADDR;
        idx_s    = offset_s[IDX_W+1:2];
        err_s    = (offset_s[1:0] != 2'b00)
                || (addr_r < BASE_ADDR)
                || (offset_s[31:IDX_W+2] != {(30-IDX_W){1'b0}});
    end

    // Next-state and response logic; responses are zero unless completing.
    always_comb begin
        next_state_s = state_r;
        ready_s      = 1'b0;
        slverr_s     = 1'b0;
        rdata_s      = 32'h0000_0000;
        do_write_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Psel && !Penable) begin
                    next_state_s = ST_ACCESS;
                end else if (Psel && Penable) begin
                    // Access phase without a setup phase: reject immediately.
                    ready_s  = 1'b1;
                    slverr_s = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!Psel) begin
                    next_state_s = ST_IDLE;
                end else if (Penable && (cnt_r == 4'd0)) begin
                    ready_s      = 1'b1;
                    next_state_s = ST_IDLE;
                    if (err_s) begin
                        slverr_s = 1'b1;
                    end else if (write_r) begin
                        do_write_s = 1'b1;
                    end else begin
                        rdata_s = mem_r[idx_s];
                    end
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, wait counter and setup-phase capture registers.
    always_ff @(posedge Pclk) begin
        if (!Presetn) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= 32'h0000_0000;
            write_r <= 1'b0;
            wdata_r <= 32'h0000_0000;
        end else begin
            state_r <= next_state_s;
            if ((state_r == ST_IDLE) && Psel && !Penable) begin
                cnt_r   <= WS_LD;
                addr_r  <= Paddr;
                write_r <= Pwrite;
                wdata_r <= Pdata;
            end else if ((state_r == ST_ACCESS) && Psel && Penable && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Register memory; reset wins over a write completing on the same edge.
    always_ff @(posedge Pclk) begin
        if (!Presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (do_write_s) begin
            mem_r[idx_s] <= wdata_r;
        end else begin
            mem_r[idx_s] <= mem_r[idx_s];
        end
    end

    assign Pready  = ready_s;
    assign Pslverr = slverr_s;
    assign Prdata  = rdata_s;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Testbench for apb_slave_mem: one instance with zero wait states and one
// with two, sharing clock, reset and bus wires; Psel is steered to one of
// them at a time.  A plain array per instance models the memory contents.
module tb_apb_slave_mem;

    logic        clk;
    logic        presetn;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pdata;
    int          cur;

    logic        psel0, psel2;
    logic        ready0, ready2, slverr0, slverr2;
    logic [31:0] rdata0, rdata2;
    logic        o_ready, o_slverr;
    logic [31:0] o_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [2][16];

    assign psel0    = psel && (cur == 0);
    assign psel2    = psel && (cur == 1);
    assign o_ready  = (cur == 0) ? ready0  : ready2;
    assign o_slverr = (cur == 0) ? slverr0 : slverr2;
    assign o_rdata  = (cur == 0) ? rdata0  : rdata2;

    apb_slave_mem #(.DEPTH(16), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) u_ws0 (
        .Pclk(clk), .Presetn(presetn), .Psel(psel0), .Penable(penable),
        .Pwrite(pwrite), .Paddr(paddr), .Pdata(pdata),
        .Pready(ready0), .Prdata(rdata0), .Pslverr(slverr0)
    );

    apb_slave_mem #(.DEPTH(16), .WAIT_STATES(2), .BASE_ADDR(32'h0000_0000)) u_ws2 (
        .Pclk(clk), .Presetn(presetn), .Psel(psel2), .Penable(penable),
        .Pwrite(pwrite), .Paddr(paddr), .Pdata(pdata),
        .Pready(ready2), .Prdata(rdata2), .Pslverr(slverr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled on
    // the falling edge, well clear of the active edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input int n, input string tag);
        psel    = 1'b0;
        penable = 1'b0;
        for (int i = 0; i < n; i++) begin
            #4;
            chk({tag, "_ready"},  {31'd0, o_ready},  32'd0);
            chk({tag, "_slverr"}, {31'd0, o_slverr}, 32'd0);
            chk({tag, "_rdata"},  o_rdata,           32'd0);
            next_cycle();
        end
    endtask

    function automatic void clear_models();
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++)
                model[d][w] = 32'h0000_0000;
    endfunction

    // One complete APB transfer on instance d, checked against the model.
    // Expected latency: setup + WAIT_STATES + 1 access cycles.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data);
        int          ws;
        int          cyc;
        int          idx;
        logic        done;
        logic        exp_err;
        logic [31:0] exp_rd;
        ws      = (d == 0) ? 0 : 2;
        exp_err = (addr[1:0] != 2'b00) || (addr >= 32'd64);
        idx     = int'(addr[5:2]);
        exp_rd  = (exp_err || wr) ? 32'h0000_0000 : model[d][idx];
        cur     = d;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pdata   = data;
        #4;
        chk("setup_ready", {31'd0, o_ready}, 32'd0);
        next_cycle();
        penable = 1'b1;
        // Bus values after setup must be ignored by the slave.
        paddr   = $urandom;
        pdata   = $urandom;
        pwrite  = ~wr;
        cyc     = 1;
        done    = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            #4;
            cyc++;
            if (o_ready) begin
                done = 1'b1;
                chk("slverr", {31'd0, o_slverr}, {31'd0, exp_err});
                chk("rdata",  o_rdata,           exp_rd);
            end
            next_cycle();
        end
        chk("latency", 32'(cyc), 32'(ws + 2));
        if (wr && !exp_err) model[d][idx] = data;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        logic        wr;
        logic [31:0] a;
        int          d;

        cur     = 0;
        presetn = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0000_0000;
        pdata   = 32'h0000_0000;
        clear_models();

        // 1. Reset for two edges, then idle with outputs quiet.
        next_cycle();
        next_cycle();
        presetn = 1'b1;
        cur = 0; idle_chk(5, "idle0");
        cur = 1; idle_chk(2, "idle2");
        xfer(0, 1'b0, 32'h0000_0000, 32'h0);
        xfer(0, 1'b0, 32'h0000_003C, 32'h0);
        xfer(1, 1'b0, 32'h0000_0014, 32'h0);

        // 2. Write then read with two wait states.
        xfer(1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        xfer(1, 1'b0, 32'h0000_0008, 32'h0);
        chk("rd_deadbeef_model", model[1][2], 32'hDEAD_BEEF);

        // 3. Zero wait states, back-to-back fill and readback.
        for (int i = 0; i < 16; i++)
            xfer(0, 1'b1, 32'(i * 4), 32'(i) * 32'h1111_1111);
        for (int i = 0; i < 16; i++)
            xfer(0, 1'b0, 32'(i * 4), 32'h0);

        // 4. Error decode: out of range and misaligned.
        xfer(0, 1'b0, 32'h0000_0040, 32'h0);
        xfer(0, 1'b1, 32'h0000_0006, 32'hFFFF_FFFF);
        xfer(0, 1'b0, 32'h0000_0004, 32'h0);

        // 5. Abort: Psel dropped in the first access cycle.
        cur     = 0;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h0000_0004;
        pdata   = 32'h1234_5678;
        next_cycle();
        idle_chk(3, "abort");
        xfer(0, 1'b0, 32'h0000_0004, 32'h0);
        chk("abort_keep_model", model[0][1], 32'h1111_1111);

        // 6a. Access phase with no setup phase.
        for (int dd = 0; dd < 2; dd++) begin
            cur     = dd;
            psel    = 1'b1;
            penable = 1'b1;
            pwrite  = 1'b1;
            paddr   = 32'h0000_0000;
            pdata   = 32'hBAD0_BAD0;
            #4;
            chk("viol_ready",  {31'd0, o_ready},  32'd1);
            chk("viol_slverr", {31'd0, o_slverr}, 32'd1);
            chk("viol_rdata",  o_rdata,           32'd0);
            next_cycle();
            idle_chk(1, "viol_after");
            xfer(dd, 1'b0, 32'h0000_0000, 32'h0);
        end

        // 6b. Reset lands on the edge that would complete a write.
        xfer(1, 1'b1, 32'h0000_000C, 32'h5555_AAAA);
        cur     = 1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h0000_0010;
        pdata   = 32'hCAFE_F00D;
        next_cycle();
        penable = 1'b1;
        next_cycle();
        next_cycle();
        presetn = 1'b0;
        next_cycle();
        presetn = 1'b1;
        clear_models();
        idle_chk(3, "rst_mid");
        xfer(1, 1'b0, 32'h0000_0010, 32'h0);
        xfer(1, 1'b0, 32'h0000_000C, 32'h0);
        xfer(0, 1'b0, 32'h0000_0004, 32'h0);

        // Randomized traffic against the model, including error addresses.
        for (int n = 0; n < 80; n++) begin
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 19)) * 32'd4;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            xfer(d, wr, a, $urandom);
            if ($urandom_range(0, 3) == 0) idle_chk(1, "rand_gap");
        end
        for (int dd = 0; dd < 2; dd++)
            for (int i = 0; i < 16; i++)
                xfer(dd, 1'b0, 32'(i * 4), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB completer that sits directly downstream of the AHB-to-APB bridge.
- Consumes the bridge's Psel/Penable/Pwrite/Paddr/Pdata and returns Pready/Prdata/Pslverr.
- Holds a small word-addressed register memory and inserts a programmable number of wait states.
- Used as the bridge's bus-functional target and as the default peripheral in the top-level integration.

Parameters:
- DEPTH, 16, number of 32-bit words (power of 2, 2..256).
- WAIT_STATES, 2, Pready-low cycles inserted in the access phase (0..15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH*4 aligned).

Ports:
- Pclk  in  1  APB clock; all state updates on rising edge.
- Presetn  in  1  synchronous active-low reset, sampled on Pclk rising edge.
- Psel  in  1  slave select.
- Penable  in  1  access-phase strobe.
- Pwrite  in  1  1=write, 0=read.
- Paddr  in  32  byte address.
- Pdata  in  32  write data.
- Pready  out  1  transfer complete.
- Prdata  out  32  read data.
- Pslverr  out  1  error response, valid only while Pready=1.

Behaviour:
- Reset (Presetn=0 at an edge):
  - State goes to IDLE and the wait counter clears.
  - All memory words clear to 0.
  - From the following cycle Pready=0, Prdata=0, Pslverr=0.
  - Reset mid-transfer aborts the transfer; no memory write occurs.
- FSM states are IDLE and ACCESS.
- IDLE:
  - Psel=1, Penable=0 (setup) -> ACCESS.
  - On that setup edge, latch Paddr, Pwrite, Pdata; load the counter with WAIT_STATES.
  - Psel=1, Penable=1 (protocol violation, no setup seen): same cycle Pready=1, Pslverr=1, Prdata=0, no write; stay IDLE.
  - Otherwise stay IDLE with Pready=0.
- ACCESS:
  - Psel=0 -> IDLE. Abort, no write, Pready=0.
  - Psel=1, Penable=1, counter!=0: counter decrements, Pready=0.
  - Psel=1, Penable=1, counter==0: Pready=1 combinationally this cycle, then -> IDLE.
  - Psel=1, Penable=0: hold the counter, Pready=0.
- Latency: setup cycle, then WAIT_STATES+1 access cycles. Pready rises in access cycle WAIT_STATES+1.
  - With WAIT_STATES=0 a transfer takes 2 Pclk cycles.
- Address decode uses the latched address only; Paddr changes during ACCESS are ignored.
  - index = (addr - BASE_ADDR) >> 2.
  - Error if addr[1:0]!=0, addr < BASE_ADDR, or index >= DEPTH.
- Error response: Pslverr=1 while Pready=1; no write; Prdata=0.
- Write: on the completing edge (Pready=1, latched write=1, no error), mem[index] <= latched data.
- Read: Prdata = mem[index] while Pready=1 and no error; Prdata = 0 at all other times. No X ever driven.
- Back-to-back: the cycle after completion the FSM is in IDLE, so a setup there starts the next transfer. Sustained throughput is one transfer per WAIT_STATES+2 cycles.
- Read-after-write to the same index returns the new data on the next transfer.
- Counter width is 4 bits; WAIT_STATES>15 is illegal (elaboration check).

Test Plan:
1. Reset and idle:
   - Stimulus: Presetn=0 for 2 edges, then release; Psel=0 for 5 cycles.
   - Required: Pready=0, Prdata=0, Pslverr=0 throughout; reading any word afterwards returns 0.
2. Write then read, WAIT_STATES=2:
   - Stimulus: write 32'hDEAD_BEEF to 32'h0000_0008, then read 32'h0000_0008.
   - Required: each transfer has Pready low for 2 access cycles, high on the 3rd (4 cycles setup-to-done); read returns Prdata=32'hDEAD_BEEF, Pslverr=0.
3. Zero wait, back-to-back:
   - Stimulus: WAIT_STATES=0; write words 0..15 with data = index*32'h1111_1111, no idle cycles; read all back.
   - Required: each transfer completes in 2 cycles; every readback matches.
4. Error decode:
   - Stimulus: read 32'h0000_0040 (index 16); write 32'h0000_0006 (misaligned).
   - Required: Pready=1 with Pslverr=1, Prdata=0; memory unchanged on re-read of word 1.
5. Abort:
   - Stimulus: start a write of 32'h1234_5678 to 32'h0000_0004; drop Psel in the first access cycle.
   - Required: FSM returns to IDLE, Pready never rises, word 1 keeps its old value.
6. Protocol violation and reset mid-transfer:
   - Stimulus: Psel=1, Penable=1 straight from IDLE.
     - Required: Pready=1, Pslverr=1 that cycle.
   - Stimulus: start a write, assert Presetn=0 during the wait states.
     - Required: no write occurs; all outputs are 0 after reset.
